// File: rtl/mem_clear_pkg.sv
// Shared types and constants for the memory clear engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_clear_pkg;

    // Per-channel sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_NEXT = 2'd2,
        ST_FIN  = 2'd3
    } chan_state_t;

    // Fill pattern encodings, as presented on the mode input
    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_ONES = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;
    localparam logic [1:0] MODE_ADDR = 2'd3;

    // Fibonacci feedback taps 64,63,61,60 (bits 63,62,60,59)
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One shift of the 64-bit maximal-length LFSR
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_clear_chan.sv
// One write channel of the clear engine: burst sequencer, address counter, pattern generator.
// Latency: first beat presented one cycle after start_go; one idle cycle between bursts.
// Backpressure: ch_busy holds ch_we/ch_addr/ch_din stable; beat accepted when ch_we & !ch_busy.
// The LFSR fill is built only when MEM_CLEAR_LFSR_EN is defined; otherwise mode 2 fills zeros.
module mem_clear_chan
    import mem_clear_pkg::*;
#(
    parameter int                ADDR_W    = 25,
    parameter int                DATA_W    = 64,
    parameter int                BURST_LEN = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '0
`ifdef MEM_CLEAR_LFSR_EN
    ,
    parameter logic [63:0]       LFSR_SEED = 64'h1
`endif
)(
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              start_go,
    input  logic              abort_req,
    input  logic [1:0]        mode,
    input  logic              ch_busy,
    output logic              ch_we,
    output logic [ADDR_W-1:0] ch_addr,
    output logic [DATA_W-1:0] ch_din,
    output logic              running,
    output logic              fin
);

    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);

    chan_state_t state;
    logic [7:0]  beat;
    logic [1:0]  mode_q;
    logic [63:0] lfsr_q;
    logic [63:0] lfsr_nx;
    logic        accept;

    assign accept  = (state == ST_BEAT) && ch_we && !ch_busy;
    assign running = (state == ST_BEAT) || (state == ST_NEXT);
    assign fin     = (state == ST_FIN);

    // Data word for a given beat; address mode truncates/zero-extends, LFSR replicates every 64 bits
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [7:0]        idx,
        input logic [63:0]       l
    );
        logic [DATA_W-1:0] p;
        logic [ADDR_W-1:0] sum;
        p   = '0;
        sum = a + ADDR_W'(idx);
        case (m)
            MODE_ZERO: p = '0;
            MODE_ONES: p = '1;
            MODE_LFSR: for (int k = 0; k < DATA_W; k++) p[k] = l[k % 64];
            MODE_ADDR: p = DATA_W'(sum);
            default:   p = '0;
        endcase
        return p;
    endfunction

`ifdef MEM_CLEAR_LFSR_EN
    assign lfsr_nx = lfsr_next(lfsr_q);

    // LFSR advances once per accepted beat; it is seeded only by reset, so passes continue the sequence.
    // With XOR feedback an all-zero seed never leaves zero.
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= lfsr_nx;
        end
    end
`else
    assign lfsr_q  = '0;
    assign lfsr_nx = '0;
`endif

    // Burst sequencer: outputs are registered, so a held beat stays put while ch_busy is high
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            ch_we   <= 1'b0;
            ch_addr <= '0;
            ch_din  <= '0;
            beat    <= '0;
            mode_q  <= MODE_ZERO;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start_go) begin
                        state   <= ST_BEAT;
                        ch_we   <= 1'b1;
                        ch_addr <= '0;
                        beat    <= '0;
                        mode_q  <= mode;
                        ch_din  <= pattern(mode, '0, 8'd0, lfsr_q);
                    end
                end
                ST_BEAT: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_NEXT;
                            ch_we <= 1'b0;
                        end else begin
                            beat   <= beat + 8'd1;
                            ch_din <= pattern(mode_q, ch_addr, beat + 8'd1, lfsr_nx);
                        end
                    end
                end
                ST_NEXT: begin
                    // The address never wraps: the final burst or a pending abort ends the pass
                    if ((ch_addr == LAST_ADDR) || abort_req) begin
                        state <= ST_FIN;
                    end else begin
                        state   <= ST_BEAT;
                        ch_we   <= 1'b1;
                        ch_addr <= ch_addr + BURST_STEP;
                        beat    <= '0;
                        ch_din  <= pattern(mode_q, ch_addr + BURST_STEP, 8'd0, lfsr_q);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ch_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_clear_engine.sv
// Multi-channel memory clear engine: fills every channel from address 0 up to LAST_ADDR in bursts.
// Latency: first beat one cycle after start; done one cycle after the last channel finishes.
// Backpressure: per-channel ch_busy stalls only that channel. Build option MEM_CLEAR_LFSR_EN adds the LFSR fill.
module mem_clear_engine
    import mem_clear_pkg::*;
#(
    parameter int              CHANNELS  = 2,
    parameter int              ADDR_W    = 25,
    parameter int              DATA_W    = 64,
    parameter int              BURST_LEN = 8,
    parameter longint unsigned LAST_ADDR = (64'd1 << ADDR_W) - 64'(BURST_LEN)
)(
    input  logic                         clk_sys,
    input  logic                         RESET,
    input  logic                         start,
    input  logic                         abort,
    input  logic [1:0]                   mode,
    output logic [CHANNELS-1:0]          ch_we,
    output logic [CHANNELS*ADDR_W-1:0]   ch_addr,
    output logic [CHANNELS*DATA_W-1:0]   ch_din,
    output logic [CHANNELS*DATA_W/8-1:0] ch_be,
    output logic [CHANNELS*8-1:0]        ch_burstcnt,
    input  logic [CHANNELS-1:0]          ch_busy,
    output logic                         active,
    output logic                         done,
    output logic [CHANNELS-1:0]          ch_done
);

    logic [CHANNELS-1:0] run_vec;
    logic [CHANNELS-1:0] fin_vec;
    logic                start_go;
    logic                abort_lat;
    logic                abort_req;

    // A start while any channel is mid-pass is dropped
    assign start_go  = start && !active;
    // Abort is honoured at the next burst boundary, including one arriving in that very cycle
    assign abort_req = abort_lat || abort;

    assign active      = |run_vec;
    assign ch_done     = fin_vec;
    assign ch_be       = '1;
    assign ch_burstcnt = {CHANNELS{8'(BURST_LEN)}};

    // Abort latch: held for the rest of the pass, cleared by the next accepted start
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            abort_lat <= 1'b0;
        end else if (start_go) begin
            abort_lat <= 1'b0;
        end else if (abort && active) begin
            abort_lat <= 1'b1;
        end
    end

    // Pass completion flag: set once every channel has reached FIN, cleared by start
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            done <= 1'b0;
        end else if (start_go) begin
            done <= 1'b0;
        end else if (&fin_vec) begin
            done <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        mem_clear_chan #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .BURST_LEN (BURST_LEN),
            .LAST_ADDR (ADDR_W'(LAST_ADDR))
`ifdef MEM_CLEAR_LFSR_EN
            ,
            .LFSR_SEED (64'h1 ^ 64'(i))
`endif
        ) u_chan (
            .clk_sys   (clk_sys),
            .RESET     (RESET),
            .start_go  (start_go),
            .abort_req (abort_req),
            .mode      (mode),
            .ch_busy   (ch_busy[i]),
            .ch_we     (ch_we[i]),
            .ch_addr   (ch_addr[i*ADDR_W +: ADDR_W]),
            .ch_din    (ch_din[i*DATA_W +: DATA_W]),
            .running   (run_vec[i]),
            .fin       (fin_vec[i])
        );
    end

endmodule

// File: tb/tb_mem_clear_engine.sv
// Directed bench for mem_clear_engine: 2 channels, 4-beat bursts, final burst at address 12.
// Latency: n/a.
// Backpressure: ch_busy driven per step to stall individual channels.
module tb_mem_clear_engine;

    localparam int CH = 2;
    localparam int AW = 8;
    localparam int DW = 64;

`ifdef MEM_CLEAR_LFSR_EN
    localparam logic [63:0] EXP_W0 = 64'h1;
    localparam logic [63:0] EXP_W1 = 64'h2;
`else
    localparam logic [63:0] EXP_W0 = 64'h0;
    localparam logic [63:0] EXP_W1 = 64'h0;
`endif

    logic                 clk_sys = 1'b0;
    logic                 RESET   = 1'b0;
    logic                 start   = 1'b0;
    logic                 abort   = 1'b0;
    logic [1:0]           mode    = 2'd0;
    logic [CH-1:0]        ch_busy = '0;
    logic [CH-1:0]        ch_we;
    logic [CH*AW-1:0]     ch_addr;
    logic [CH*DW-1:0]     ch_din;
    logic [CH*DW/8-1:0]   ch_be;
    logic [CH*8-1:0]      ch_burstcnt;
    logic                 active;
    logic                 done;
    logic [CH-1:0]        ch_done;

    int checks   = 0;
    int failures = 0;

    int          n0 = 0;
    int          n1 = 0;
    logic [7:0]  log_addr [0:255];
    logic [63:0] log_dat  [0:255];

    mem_clear_engine #(
        .CHANNELS  (CH),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (4),
        .LAST_ADDR (64'd12)
    ) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .ch_we       (ch_we),
        .ch_addr     (ch_addr),
        .ch_din      (ch_din),
        .ch_be       (ch_be),
        .ch_burstcnt (ch_burstcnt),
        .ch_busy     (ch_busy),
        .active      (active),
        .done        (done),
        .ch_done     (ch_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Record every beat accepted on channel 0 and count channel 1 beats
    always @(posedge clk_sys) begin
        if (RESET && ch_we[0] && !ch_busy[0]) begin
            log_addr[n0[7:0]] <= ch_addr[AW-1:0];
            log_dat[n0[7:0]]  <= ch_din[DW-1:0];
            n0 <= n0 + 1;
        end
        if (RESET && ch_we[1] && !ch_busy[1]) begin
            n1 <= n1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk_sys);
        mode  = m;
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && !done; k++) @(negedge clk_sys);
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int target);
        for (int k = 0; k < 400 && (n0 < target); k++) @(negedge clk_sys);
        chk(tag, 64'(n0), 64'(target));
    endtask

    initial begin
        int b;
        int b1;

        // Reset state
        RESET = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(ch_we), 64'd0);
        chk("rst_chdone", 64'(ch_done), 64'd0);
        chk("rst_addr", 64'(ch_addr), 64'd0);
        chk("rst_din0", ch_din[63:0], 64'd0);
        chk("be_ones", 64'(ch_be), 64'hFFFF);
        chk("burstcnt", 64'(ch_burstcnt), 64'h0404);
        RESET = 1'b1;

        // Full zero-fill pass: 16 beats at 0,4,8,12
        b  = n0;
        b1 = n1;
        pulse_start(2'd0);
        wait_done("p1_done");
        chk("p1_beats0", 64'(n0 - b), 64'd16);
        chk("p1_beats1", 64'(n1 - b1), 64'd16);
        for (int k = 0; k < 16; k++) begin
            chk("p1_addr", 64'(log_addr[8'(b + k)]), 64'((k / 4) * 4));
            chk("p1_data", log_dat[8'(b + k)], 64'd0);
        end
        chk("p1_chdone", 64'(ch_done), 64'd3);
        chk("p1_active", 64'(active), 64'd0);
        chk("p1_we", 64'(ch_we), 64'd0);

        // Address-as-data pass with a 5-cycle stall on beat 2 of the first burst
        b = n0;
        pulse_start(2'd3);
        wait_beats("st_reach", b + 2);
        ch_busy[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            chk("st_count", 64'(n0 - b), 64'd2);
            chk("st_we", 64'(ch_we[0]), 64'd1);
            chk("st_addr", 64'(ch_addr[AW-1:0]), 64'd0);
            chk("st_din", ch_din[63:0], 64'd2);
        end
        ch_busy[0] = 1'b0;
        wait_done("m3_done");
        chk("m3_beats", 64'(n0 - b), 64'd16);
        chk("m3_beat2", log_dat[8'(b + 2)], 64'd2);
        for (int k = 0; k < 4; k++) begin
            chk("m3_addr8", 64'(log_addr[8'(b + 8 + k)]), 64'd8);
            chk("m3_data8", log_dat[8'(b + 8 + k)], 64'(8 + k));
        end
        chk("m3_data15", log_dat[8'(b + 15)], 64'd15);

        // Abort during beat 1 of the burst at address 4
        b = n0;
        pulse_start(2'd0);
        wait_beats("ab_reach", b + 5);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        wait_done("ab_done");
        chk("ab_beats", 64'(n0 - b), 64'd8);
        chk("ab_lastaddr", 64'(log_addr[8'(b + 7)]), 64'd4);
        chk("ab_addr_reg", 64'(ch_addr[AW-1:0]), 64'd4);
        chk("ab_chdone", 64'(ch_done), 64'd3);

        // Channel 1 stuck busy: channel 0 finishes alone; done waits for channel 1
        b  = n0;
        b1 = n1;
        @(negedge clk_sys);
        ch_busy = 2'b10;
        pulse_start(2'd0);
        for (int k = 0; k < 400 && !ch_done[0]; k++) @(negedge clk_sys);
        chk("iso_chdone", 64'(ch_done), 64'd1);
        chk("iso_done", 64'(done), 64'd0);
        chk("iso_active", 64'(active), 64'd1);
        chk("iso_beats0", 64'(n0 - b), 64'd16);
        chk("iso_beats1", 64'(n1 - b1), 64'd0);
        chk("iso_we1", 64'(ch_we[1]), 64'd1);
        // A start while active must be ignored
        pulse_start(2'd1);
        chk("ign_chdone", 64'(ch_done), 64'd1);
        chk("ign_addr0", 64'(ch_addr[AW-1:0]), 64'd12);
        chk("ign_din1", ch_din[127:64], 64'd0);
        ch_busy = 2'b00;
        wait_done("iso_release");
        chk("iso_beats1b", 64'(n1 - b1), 64'd16);
        chk("iso_chdone2", 64'(ch_done), 64'd3);

        // Reset mid-burst, then restart in LFSR mode from address 0 with fresh seeds
        b = n0;
        pulse_start(2'd2);
        wait_beats("rs_reach", b + 2);
        RESET = 1'b0;
        @(negedge clk_sys);
        chk("rs_we", 64'(ch_we), 64'd0);
        chk("rs_active", 64'(active), 64'd0);
        chk("rs_done", 64'(done), 64'd0);
        chk("rs_chdone", 64'(ch_done), 64'd0);
        RESET = 1'b1;
        b = n0;
        pulse_start(2'd2);
        chk("lf_we", 64'(ch_we[0]), 64'd1);
        chk("lf_addr", 64'(ch_addr[AW-1:0]), 64'd0);
        chk("lf_din0", ch_din[63:0], EXP_W0);
        wait_done("lf_done");
        chk("lf_beats", 64'(n0 - b), 64'd16);
        chk("lf_word0", log_dat[8'(b)], EXP_W0);
        chk("lf_word1", log_dat[8'(b + 1)], EXP_W1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_clear_engine.md
MEM_CLEAR_ENGINE -- requirements
Module: mem_clear_engine

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent memory write ports.
REQ-002 SHALL have parameter ADDR_W, default 25: word-address width per channel.
REQ-003 SHALL have parameter DATA_W, default 64: data width per channel; byte enables are DATA_W/8 bits.
REQ-004 SHALL have parameter BURST_LEN, default 8, range 1..255: beats per burst.
REQ-005 SHALL have parameter LAST_ADDR, default 2**ADDR_W-BURST_LEN: start address of the final burst.
REQ-006 SHALL have port clk_sys, input, 1: clock.
REQ-007 SHALL have port RESET, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that begins a clear pass.
REQ-009 SHALL have port abort, input, 1: requests a stop at the next burst boundary.
REQ-010 SHALL have port mode, input, 2: fill pattern (0 zero, 1 all-ones, 2 LFSR, 3 address-as-data), sampled at start.
REQ-011 SHALL have port ch_we, output, CHANNELS: per-channel write request.
REQ-012 SHALL have port ch_addr, output, CHANNELS*ADDR_W: per-channel burst start address.
REQ-013 SHALL have port ch_din, output, CHANNELS*DATA_W: per-channel write data.
REQ-014 SHALL have port ch_be, output, CHANNELS*DATA_W/8: per-channel byte enables, all ones.
REQ-015 SHALL have port ch_burstcnt, output, CHANNELS*8: per-channel burst length, constant BURST_LEN.
REQ-016 SHALL have port ch_busy, input, CHANNELS: per-channel wait request.
REQ-017 SHALL have port active, output, 1: a pass is in progress.
REQ-018 SHALL have port done, output, 1: high from pass completion until the next start.
REQ-019 SHALL have port ch_done, output, CHANNELS: per-channel pass complete.

Function
REQ-020 SHALL run one FSM per channel with states IDLE, BEAT, NEXT, FIN.
- IDLE -> BEAT on start.
- BEAT -> NEXT after the last beat is accepted.
- NEXT -> BEAT for the next burst, or -> FIN if the address equals LAST_ADDR or abort is latched.
- FIN -> BEAT on start.
REQ-021 SHALL count a beat as accepted on a cycle where ch_we=1 and ch_busy=0; ch_we, ch_addr and ch_din SHALL remain stable while ch_busy=1.
REQ-022 SHALL hold ch_addr at the burst start for all beats and advance it by BURST_LEN in NEXT; NEXT SHALL last exactly one cycle with ch_we=0.
REQ-023 SHALL start every channel at address 0; channels SHALL advance independently, so one stalled channel does not stall another.
REQ-024 SHALL set mode 3 data per beat to {burst address + beat index} zero-extended to DATA_W.
REQ-025 SHALL set mode 2 data to a per-channel 64-bit maximal LFSR (taps 64,63,61,60), seeded with 64'h1 XOR the channel index and stepped once per accepted beat; for DATA_W>64 the value is replicated, for DATA_W<64 it is truncated.
REQ-026 SHALL ignore start while active=1; start SHALL clear done and ch_done.
REQ-027 SHALL latch abort until the pass ends; an abort received mid-burst SHALL complete the burst before entering FIN.
REQ-028 SHALL assert done one cycle after the last channel enters FIN; active SHALL equal the OR of the channels not in IDLE or FIN.
REQ-029 SHALL not wrap the address: reaching LAST_ADDR ends the pass.

Reset
REQ-030 SHALL, when RESET=0 at a clk_sys edge, return all FSMs to IDLE and clear ch_we, ch_addr, ch_din, done, ch_done and active, and reload the LFSR seeds.
REQ-031 SHALL, on reset mid-burst, drop ch_we on the next cycle regardless of ch_busy.

Configuration
REQ-032 SHALL compile the LFSR generator only when macro MEM_CLEAR_LFSR_EN is defined; without it, mode 2 SHALL behave identically to mode 0.

Structure
REQ-033 SHALL place the FSM state enum, the mode encodings and the LFSR tap constant in package mem_clear_pkg.
REQ-034 SHALL instantiate sub-module mem_clear_chan (FSM, address counter, pattern generator) once per channel through a generate loop; the top level holds the start/abort latch and the done aggregation.

Verification
REQ-035 With CHANNELS=1, BURST_LEN=4, LAST_ADDR=12 and mode 0, a start pulse SHALL produce 16 accepted beats at addresses 0,4,8,12, then done=1.
REQ-036 With ch_busy held at 1 for 5 cycles during beat 2, ch_we, ch_addr and ch_din SHALL stay stable and the beat count SHALL be unchanged.
REQ-037 With mode 3 and BURST_LEN=4, the beats of the burst at address 8 SHALL carry data 8,9,10,11.
REQ-038 With abort asserted during beat 1 of the burst at address 4, that burst SHALL complete and the channel SHALL go to FIN with no burst issued at address 8.
REQ-039 With CHANNELS=2 and ch_busy[1] stuck at 1, ch_done[0] SHALL assert while done=0; releasing ch_busy[1] SHALL lead to done=1.
REQ-040 With RESET=0 asserted mid-burst, ch_we SHALL be 0 on the next cycle; a subsequent start SHALL resume at address 0 with the LFSR reseeded (first mode-2 word 64'h1 on channel 0).
